// File: rtl/cpu_mem_responder_if.sv
// cpu_mem_responder_if: byte-wide cpu memory bus between the cpu (master) and
// the memory/IO responder (slave).
interface cpu_mem_responder_if;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        io_buffer_full;

   modport master (
      output mem_a,
      output mem_wr,
      output mem_dout,
      input  mem_din,
      input  io_buffer_full
   );

   modport slave (
      input  mem_a,
      input  mem_wr,
      input  mem_dout,
      output mem_din,
      output io_buffer_full
   );
endinterface

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: far side of the cpu byte bus. Backs a byte RAM and the IO
// page at mem_a[17:16]==2'b11 (UART TX/RX FIFOs, cycle counter, program stop).
// Optional feature macro: IO_CYCLE_COUNTER_EN builds the 32-bit cycle counter
// and its snapshot; without it, reads of 0x30004..0x30007 return 0x00.
module cpu_mem_responder #(
   parameter int RAM_ADDR_W = 17,
   parameter int TX_DEPTH   = 8,
   parameter int RX_DEPTH   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   cpu_mem_responder_if.slave   bus,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   output logic                 rx_ready,
   output logic                 prog_stop,
   output logic                 tx_overflow
);
   localparam int TX_PW = $clog2(TX_DEPTH);
   localparam int RX_PW = $clog2(RX_DEPTH);

   localparam logic [TX_PW:0]   TX_FULL_C     = (TX_PW + 1)'(TX_DEPTH);
   localparam logic [TX_PW:0]   TX_NEAR_C     = (TX_PW + 1)'(TX_DEPTH - 2);
   localparam logic [TX_PW:0]   TX_CNT_ZERO_C = {(TX_PW + 1){1'b0}};
   localparam logic [TX_PW:0]   TX_CNT_ONE_C  = (TX_PW + 1)'(1);
   localparam logic [TX_PW-1:0] TX_PTR_ONE_C  = TX_PW'(1);
   localparam logic [RX_PW:0]   RX_FULL_C     = (RX_PW + 1)'(RX_DEPTH);
   localparam logic [RX_PW:0]   RX_CNT_ZERO_C = {(RX_PW + 1){1'b0}};
   localparam logic [RX_PW:0]   RX_CNT_ONE_C  = (RX_PW + 1)'(1);
   localparam logic [RX_PW-1:0] RX_PTR_ONE_C  = RX_PW'(1);

   localparam logic [15:0] IO_FIFO_C  = 16'h0000;
   localparam logic [15:0] IO_SNAP0_C = 16'h0004;
`ifdef IO_CYCLE_COUNTER_EN
   localparam logic [15:0] IO_SNAP1_C = 16'h0005;
   localparam logic [15:0] IO_SNAP2_C = 16'h0006;
   localparam logic [15:0] IO_SNAP3_C = 16'h0007;
`endif

   logic [7:0]       ram_r [2**RAM_ADDR_W];
   logic [7:0]       tx_mem_r [TX_DEPTH];
   logic [7:0]       rx_mem_r [RX_DEPTH];

   logic [TX_PW-1:0] tx_wr_ptr_r, tx_rd_ptr_r;
   logic [TX_PW:0]   tx_count_r, tx_count_s;
   logic [RX_PW-1:0] rx_wr_ptr_r, rx_rd_ptr_r;
   logic [RX_PW:0]   rx_count_r, rx_count_s;

   logic [7:0]       mem_din_r;
   logic             io_buffer_full_r, tx_valid_r, rx_ready_r;
   logic             prog_stop_r, tx_overflow_r;

   logic             io_sel_s, cpu_wr_s, cpu_rd_s, ram_we_s, stop_wr_s;
   logic [15:0]      io_off_s;
   logic             tx_req_s, tx_push_s, tx_drop_s, tx_pop_s;
   logic [7:0]       tx_req_data_s;
   logic             rx_push_s, rx_pop_s;
   logic [7:0]       rd_data_s;
   logic             unused_s;

`ifdef IO_CYCLE_COUNTER_EN
   logic [31:0]      cyc_cnt_r, snap_r;
   logic             snap_ld_s;
   assign snap_ld_s = cpu_rd_s & io_sel_s & (io_off_s == IO_SNAP0_C);
`endif

   assign unused_s           = ^bus.mem_a[31:18];
   assign bus.mem_din        = mem_din_r;
   assign bus.io_buffer_full = io_buffer_full_r;
   assign tx_data            = tx_mem_r[tx_rd_ptr_r];
   assign tx_valid           = tx_valid_r;
   assign rx_ready           = rx_ready_r;
   assign prog_stop          = prog_stop_r;
   assign tx_overflow        = tx_overflow_r;

   // Decode the bus cycle into RAM/IO actions and FIFO handshakes, next counts
   always_comb begin
      io_sel_s  = (bus.mem_a[17:16] == 2'b11);
      io_off_s  = bus.mem_a[15:0];
      cpu_wr_s  = rdy & bus.mem_wr & ~prog_stop_r;
      cpu_rd_s  = rdy & ~bus.mem_wr;
      ram_we_s  = cpu_wr_s & ~io_sel_s;
      stop_wr_s = cpu_wr_s & io_sel_s & (io_off_s == IO_SNAP0_C);

      // the stop write pushes a 0x00 marker that bypasses the zero filter
      if (cpu_wr_s && io_sel_s && (io_off_s == IO_FIFO_C) && (bus.mem_dout != 8'h00)) begin
         tx_req_s      = 1'b1;
         tx_req_data_s = bus.mem_dout;
      end else if (stop_wr_s) begin
         tx_req_s      = 1'b1;
         tx_req_data_s = 8'h00;
      end else begin
         tx_req_s      = 1'b0;
         tx_req_data_s = 8'h00;
      end

      // drain is independent of rdy; a pop frees room for a push in the same cycle
      tx_pop_s  = (tx_count_r != TX_CNT_ZERO_C) & tx_ready;
      tx_push_s = tx_req_s & ((tx_count_r != TX_FULL_C) | tx_pop_s);
      tx_drop_s = tx_req_s & ~tx_push_s;
      rx_push_s = rx_valid & (rx_count_r != RX_FULL_C);
      rx_pop_s  = cpu_rd_s & io_sel_s & (io_off_s == IO_FIFO_C) & (rx_count_r != RX_CNT_ZERO_C);

      case ({tx_push_s, tx_pop_s})
         2'b10:   tx_count_s = tx_count_r + TX_CNT_ONE_C;
         2'b01:   tx_count_s = tx_count_r - TX_CNT_ONE_C;
         default: tx_count_s = tx_count_r;
      endcase
      case ({rx_push_s, rx_pop_s})
         2'b10:   rx_count_s = rx_count_r + RX_CNT_ONE_C;
         2'b01:   rx_count_s = rx_count_r - RX_CNT_ONE_C;
         default: rx_count_s = rx_count_r;
      endcase
   end

   // Read data mux: RAM byte or IO register for the address presented this cycle
   always_comb begin
      rd_data_s = 8'h00;
      if (io_sel_s) begin
         case (io_off_s)
            IO_FIFO_C: begin
               if (rx_count_r != RX_CNT_ZERO_C) begin
                  rd_data_s = rx_mem_r[rx_rd_ptr_r];
               end else begin
                  rd_data_s = 8'h00;
               end
            end
`ifdef IO_CYCLE_COUNTER_EN
            // byte 0 returns the value being latched so all four bytes are coherent
            IO_SNAP0_C: rd_data_s = cyc_cnt_r[7:0];
            IO_SNAP1_C: rd_data_s = snap_r[15:8];
            IO_SNAP2_C: rd_data_s = snap_r[23:16];
            IO_SNAP3_C: rd_data_s = snap_r[31:24];
`endif
            default: rd_data_s = 8'h00;
         endcase
      end else begin
         rd_data_s = ram_r[bus.mem_a[RAM_ADDR_W-1:0]];
      end
   end

   // RAM write port; contents survive reset
   always_ff @(posedge clk) begin
      if (rst && ram_we_s) begin
         ram_r[bus.mem_a[RAM_ADDR_W-1:0]] <= bus.mem_dout;
      end
   end

   // FIFO storage; occupancy is tracked by the counters, so no reset needed
   always_ff @(posedge clk) begin
      if (rst && tx_push_s) begin
         tx_mem_r[tx_wr_ptr_r] <= tx_req_data_s;
      end
      if (rst && rx_push_s) begin
         rx_mem_r[rx_wr_ptr_r] <= rx_data;
      end
   end

   // Control state: read data, FIFO pointers/counts, status outputs, sticky flags
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_din_r        <= 8'h00;
         tx_wr_ptr_r      <= {TX_PW{1'b0}};
         tx_rd_ptr_r      <= {TX_PW{1'b0}};
         tx_count_r       <= TX_CNT_ZERO_C;
         rx_wr_ptr_r      <= {RX_PW{1'b0}};
         rx_rd_ptr_r      <= {RX_PW{1'b0}};
         rx_count_r       <= RX_CNT_ZERO_C;
         tx_valid_r       <= 1'b0;
         rx_ready_r       <= 1'b1;
         io_buffer_full_r <= 1'b0;
         prog_stop_r      <= 1'b0;
         tx_overflow_r    <= 1'b0;
`ifdef IO_CYCLE_COUNTER_EN
         cyc_cnt_r        <= 32'h0000_0000;
         snap_r           <= 32'h0000_0000;
`endif
      end else begin
         if (cpu_rd_s)  mem_din_r   <= rd_data_s;
         if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + TX_PTR_ONE_C;
         if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + TX_PTR_ONE_C;
         if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + RX_PTR_ONE_C;
         if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + RX_PTR_ONE_C;
         tx_count_r       <= tx_count_s;
         rx_count_r       <= rx_count_s;
         tx_valid_r       <= (tx_count_s != TX_CNT_ZERO_C);
         io_buffer_full_r <= (tx_count_s >= TX_NEAR_C);
         rx_ready_r       <= (rx_count_s != RX_FULL_C);
         if (tx_drop_s) tx_overflow_r <= 1'b1;
         if (stop_wr_s) prog_stop_r   <= 1'b1;
`ifdef IO_CYCLE_COUNTER_EN
         if (rdy)       cyc_cnt_r     <= cyc_cnt_r + 32'd1;
         if (snap_ld_s) snap_r        <= cyc_cnt_r;
`endif
      end
   end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based behavioural model of the responder.
module tb_cpu_mem_responder;
   localparam int TX_DEPTH = 8;
   localparam int RX_DEPTH = 8;
   localparam logic [31:0] IDLE_A = 32'h0003_0008;
   localparam logic [31:0] A_FIFO = 32'h0003_0000;
   localparam logic [31:0] A_STOP = 32'h0003_0004;
`ifdef IO_CYCLE_COUNTER_EN
   localparam logic [7:0] T5_FIRST = 8'h64;
   localparam logic [7:0] T5_LATER = 8'h69;
`else
   localparam logic [7:0] T5_FIRST = 8'h00;
   localparam logic [7:0] T5_LATER = 8'h00;
`endif

   logic       clk = 1'b0;
   logic       rst, rdy, tx_ready, rx_valid;
   logic [7:0] rx_data, tx_data;
   logic       tx_valid, rx_ready, prog_stop, tx_overflow;

   cpu_mem_responder_if bus_if ();

   cpu_mem_responder dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .bus         (bus_if),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .prog_stop   (prog_stop),
      .tx_overflow (tx_overflow)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // behavioural model state
   logic [7:0]  m_ram [int];
   int          ram_keys[$];
   logic [7:0]  m_tx_q[$];
   logic [7:0]  m_rx_q[$];
   logic [7:0]  m_din;
   logic        m_stop, m_ovf;
   logic [31:0] m_cyc, m_snap;
   logic [7:0]  dut_log[$];

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void tx_offer(input logic [7:0] b);
      if (m_tx_q.size() < TX_DEPTH) m_tx_q.push_back(b);
      else m_ovf = 1'b1;
   endfunction

   // one clock edge of the model, using the inputs present before the edge
   function automatic void model_edge();
      logic        rx_take, tx_take, io;
      logic [15:0] off;
      int          key;
      if (!rst) begin
         m_tx_q.delete(); m_rx_q.delete();
         m_din = 8'h00; m_stop = 1'b0; m_ovf = 1'b0; m_cyc = 32'd0; m_snap = 32'd0;
         return;
      end
      tx_take = (m_tx_q.size() != 0) && tx_ready;
      rx_take = rx_valid && (m_rx_q.size() < RX_DEPTH);
      if (tx_take) void'(m_tx_q.pop_front());
      io  = (bus_if.mem_a[17:16] == 2'b11);
      off = bus_if.mem_a[15:0];
      key = int'(bus_if.mem_a[16:0]);
      if (rdy) begin
         if (bus_if.mem_wr) begin
            if (!m_stop) begin
               if (!io) begin
                  if (!m_ram.exists(key)) ram_keys.push_back(key);
                  m_ram[key] = bus_if.mem_dout;
               end else if (off == 16'h0000 && bus_if.mem_dout != 8'h00) begin
                  tx_offer(bus_if.mem_dout);
               end else if (off == 16'h0004) begin
                  m_stop = 1'b1;
                  tx_offer(8'h00);
               end
            end
         end else if (!io) begin
            m_din = m_ram[key];
         end else begin
            case (off)
               16'h0000: m_din = (m_rx_q.size() != 0) ? m_rx_q.pop_front() : 8'h00;
`ifdef IO_CYCLE_COUNTER_EN
               16'h0004: begin m_snap = m_cyc; m_din = m_snap[7:0]; end
               16'h0005: m_din = m_snap[15:8];
               16'h0006: m_din = m_snap[23:16];
               16'h0007: m_din = m_snap[31:24];
`endif
               default:  m_din = 8'h00;
            endcase
         end
         m_cyc = m_cyc + 32'd1;
      end
      if (rx_take) m_rx_q.push_back(rx_data);
   endfunction

   task automatic compare_all();
      check_value("mem_din", {24'h0, bus_if.mem_din}, {24'h0, m_din});
      check_value("tx_valid", {31'h0, tx_valid}, {31'h0, m_tx_q.size() != 0});
      if (m_tx_q.size() != 0) check_value("tx_data", {24'h0, tx_data}, {24'h0, m_tx_q[0]});
      check_value("io_buffer_full", {31'h0, bus_if.io_buffer_full}, {31'h0, m_tx_q.size() >= TX_DEPTH - 2});
      check_value("rx_ready", {31'h0, rx_ready}, {31'h0, m_rx_q.size() != RX_DEPTH});
      check_value("prog_stop", {31'h0, prog_stop}, {31'h0, m_stop});
      check_value("tx_overflow", {31'h0, tx_overflow}, {31'h0, m_ovf});
   endtask

   task automatic tick();
      if (rst && tx_valid && tx_ready) dut_log.push_back(tx_data);
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic bus_op(input logic [31:0] addr, input logic wr, input logic [7:0] data);
      bus_if.mem_a = addr; bus_if.mem_wr = wr; bus_if.mem_dout = data;
      tick();
      bus_if.mem_a = IDLE_A; bus_if.mem_wr = 1'b0; bus_if.mem_dout = 8'h00;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   initial begin
      logic [31:0] a;
      int          sel;
      rst = 1'b0; rdy = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      bus_if.mem_a = IDLE_A; bus_if.mem_wr = 1'b0; bus_if.mem_dout = 8'h00;

      // reset state
      tick();
      rst = 1'b1;
      check_value("rst_mem_din", {24'h0, bus_if.mem_din}, 32'h0);
      check_value("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check_value("rst_rx_ready", {31'h0, rx_ready}, 32'h1);

      // T1: RAM write then read back
      bus_op(32'h0000_0010, 1'b1, 8'hA5);
      bus_op(32'h0000_0010, 1'b0, 8'h00);
      check_value("t1_ram_rd", {24'h0, bus_if.mem_din}, 32'hA5);

      // T2: one byte through TX, zero write filtered
      tx_ready = 1'b1; dut_log.delete();
      bus_op(A_FIFO, 1'b1, 8'h48);
      check_value("t2_valid", {31'h0, tx_valid}, 32'h1);
      check_value("t2_data", {24'h0, tx_data}, 32'h48);
      bus_op(A_FIFO, 1'b1, 8'h00);
      idle(4);
      check_value("t2_count", dut_log.size(), 32'd1);
      if (dut_log.size() != 0) check_value("t2_byte", {24'h0, dut_log[0]}, 32'h48);

      // T3: fill TX, nearly-full flag, overflow, ordered drain
      tx_ready = 1'b0; dut_log.delete();
      for (int i = 0; i < 9; i++) begin
         bus_op(A_FIFO, 1'b1, 8'h41 + 8'(i));
         if (i == 4) check_value("t3_nf_5", {31'h0, bus_if.io_buffer_full}, 32'h0);
         if (i == 5) check_value("t3_nf_6", {31'h0, bus_if.io_buffer_full}, 32'h1);
         if (i == 7) check_value("t3_ovf_8", {31'h0, tx_overflow}, 32'h0);
      end
      check_value("t3_ovf_9", {31'h0, tx_overflow}, 32'h1);
      tx_ready = 1'b1;
      idle(10);
      check_value("t3_drain_n", dut_log.size(), 32'd8);
      for (int k = 0; k < 8; k++)
         if (k < dut_log.size()) check_value("t3_drain", {24'h0, dut_log[k]}, 32'h41 + 32'(k));

      // T4: RX byte read once, then empty read
      rx_valid = 1'b1; rx_data = 8'h31;
      tick();
      rx_valid = 1'b0;
      bus_op(A_FIFO, 1'b0, 8'h00);
      check_value("t4_rd", {24'h0, bus_if.mem_din}, 32'h31);
      bus_op(A_FIFO, 1'b0, 8'h00);
      check_value("t4_empty", {24'h0, bus_if.mem_din}, 32'h0);
      check_value("t4_ready", {31'h0, rx_ready}, 32'h1);

      // RX full: ready drops, pop returns the old head while push is refused
      rx_valid = 1'b1;
      for (int i = 0; i < RX_DEPTH; i++) begin rx_data = 8'h70 + 8'(i); tick(); end
      check_value("rx_full_ready", {31'h0, rx_ready}, 32'h0);
      rx_data = 8'hEE;
      bus_op(A_FIFO, 1'b0, 8'h00);
      check_value("rx_full_pop", {24'h0, bus_if.mem_din}, 32'h70);
      rx_valid = 1'b0;

      // T5: cycle counter snapshot and freeze while rdy is low
      do_reset();
      idle(100);
      bus_op(A_STOP, 1'b0, 8'h00);
      check_value("t5_b0", {24'h0, bus_if.mem_din}, {24'h0, T5_FIRST});
      for (int i = 5; i < 8; i++) begin
         bus_op(32'h0003_0000 + 32'(i), 1'b0, 8'h00);
         check_value("t5_bn", {24'h0, bus_if.mem_din}, 32'h0);
      end
      bus_op(32'h0000_0010, 1'b0, 8'h00);
      check_value("t5_ram_kept", {24'h0, bus_if.mem_din}, 32'hA5);
      rdy = 1'b0;
      for (int i = 0; i < 10; i++) bus_op(A_STOP, 1'b0, 8'h00);
      check_value("t5_hold", {24'h0, bus_if.mem_din}, 32'hA5);
      rdy = 1'b1;
      bus_op(A_STOP, 1'b0, 8'h00);
      check_value("t5_frozen", {24'h0, bus_if.mem_din}, {24'h0, T5_LATER});

      // T6: program stop emits 0x00 and blocks later writes
      tx_ready = 1'b1; dut_log.delete();
      bus_op(A_STOP, 1'b1, 8'h99);
      check_value("t6_stop", {31'h0, prog_stop}, 32'h1);
      check_value("t6_valid", {31'h0, tx_valid}, 32'h1);
      check_value("t6_data", {24'h0, tx_data}, 32'h0);
      bus_op(A_FIFO, 1'b1, 8'h41);
      idle(3);
      check_value("t6_ign_valid", {31'h0, tx_valid}, 32'h0);
      check_value("t6_emitted", dut_log.size(), 32'd1);
      bus_op(32'h0000_0010, 1'b1, 8'h5A);
      bus_op(32'h0000_0010, 1'b0, 8'h00);
      check_value("t6_ram_ign", {24'h0, bus_if.mem_din}, 32'hA5);

      // reset in the middle of a TX drain
      do_reset();
      tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) bus_op(A_FIFO, 1'b1, 8'h61 + 8'(i));
      rx_valid = 1'b1; rx_data = 8'h12;
      bus_op(32'h0000_0010, 1'b0, 8'h00);
      rx_valid = 1'b0;
      check_value("t6_pre_ovf", {31'h0, tx_overflow}, 32'h1);
      tx_ready = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check_value("t6_rst_din", {24'h0, bus_if.mem_din}, 32'h0);
      check_value("t6_rst_valid", {31'h0, tx_valid}, 32'h0);
      check_value("t6_rst_nf", {31'h0, bus_if.io_buffer_full}, 32'h0);
      check_value("t6_rst_ovf", {31'h0, tx_overflow}, 32'h0);
      check_value("t6_rst_rxr", {31'h0, rx_ready}, 32'h1);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         rdy      = ($urandom_range(9) != 0);
         tx_ready = 1'($urandom_range(1));
         rx_valid = ($urandom_range(2) == 0);
         rx_data  = 8'($urandom);
         rst      = ($urandom_range(399) != 0);
         sel      = $urandom_range(99);
         a        = $urandom;
         a[17]    = 1'b0;
         bus_if.mem_wr = 1'b0; bus_if.mem_dout = 8'($urandom);
         if (sel < 20) begin
            a[16:0] = 17'($urandom_range(31)) | (17'($urandom_range(1)) << 16);
            bus_if.mem_wr = 1'b1;
         end else if (sel < 35 && ram_keys.size() != 0) begin
            a[16:0] = 17'(ram_keys[$urandom_range(ram_keys.size() - 1)]);
         end else if (sel < 55) begin
            a = A_FIFO; bus_if.mem_wr = 1'($urandom_range(1));
            if ($urandom_range(4) == 0) bus_if.mem_dout = 8'h00;
         end else if (sel < 70) begin
            a = A_STOP + 32'($urandom_range(3));
         end else if (sel < 80) begin
            a = 32'h0003_0001 + 32'($urandom_range(7));
            bus_if.mem_wr = 1'($urandom_range(1));
            if (a == A_STOP) bus_if.mem_wr = ($urandom_range(49) == 0);
         end else begin
            a = IDLE_A;
         end
         bus_if.mem_a = a;
         tick();
      end
      rst = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
